// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      StRun,
      StMemWait,
      StRedirect
   } state_e;

   localparam logic [31:0] NopInstr = 32'h00000013;
   localparam int unsigned CntWidth = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + Width'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, MEM-stage redirect flush and load-use stall.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4:0]          id_rs1,
   input  logic [4:0]          id_rs2,
   input  logic                id_uses_rs1,
   input  logic                id_uses_rs2,
   input  logic                ex_memRead,
   input  logic [4:0]          ex_rd,
   input  logic                mem_redirect,
   input  logic                dmem_req,
   input  logic                dmem_ready,
   output logic                pc_write_en,
   output logic                if_id_write_en,
   output logic                if_id_flush,
   output logic                id_ex_bubble,
   output logic                ex_mem_bubble,
   output logic                id_ex_hold,
   output logic                ex_mem_hold,
   output logic                mem_wb_hold,
   output logic [CntWidth-1:0] stall_cnt,
   output logic [CntWidth-1:0] flush_cnt
);

   state_e state_q, state_d;
   logic   pending_q, pending_d;
   logic   lu_hazard;
   logic   freeze;
   logic   redir_seen;
   logic   redirect;
   logic   load_use;

   assign lu_hazard = ex_memRead && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      // In MEM_WAIT the access is already outstanding, so only readiness matters.
      freeze     = (state_q == StMemWait) ? !dmem_ready : (dmem_req && !dmem_ready);
      // The slot behind an applied redirect is a bubble; its redirect flag is stale.
      redir_seen = mem_redirect && (state_q != StRedirect);
      redirect   = !freeze && (redir_seen || pending_q);
      load_use   = !freeze && !redirect && (state_q != StRedirect) && lu_hazard;

      pending_d = pending_q;
      if (freeze && redir_seen) begin
         pending_d = 1'b1;
      end else if (redirect) begin
         pending_d = 1'b0;
      end

      if (freeze) begin
         state_d = StMemWait;
      end else if (redirect) begin
         state_d = StRedirect;
      end else begin
         state_d = StRun;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StRun;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      ex_mem_bubble  = 1'b0;
      id_ex_hold     = 1'b0;
      ex_mem_hold    = 1'b0;
      mem_wb_hold    = 1'b0;

      if (!rst_n) begin
         // Hold the front end and let NOPs flow down the pipe.
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         if_id_flush    = 1'b1;
         id_ex_bubble   = 1'b1;
         ex_mem_bubble  = 1'b1;
      end else if (freeze) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_hold     = 1'b1;
         ex_mem_hold    = 1'b1;
         mem_wb_hold    = 1'b1;
      end else if (redirect) begin
         if_id_flush    = 1'b1;
         id_ex_bubble   = 1'b1;
         ex_mem_bubble  = 1'b1;
      end else if (load_use) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_bubble   = 1'b1;
      end
   end

   sat_counter #(
      .Width (CntWidth)
   ) u_stall_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (freeze || load_use),
      .count (stall_cnt)
   );

   sat_counter #(
      .Width (CntWidth)
   ) u_flush_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (redirect),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_memRead;
   logic        mem_redirect, dmem_req, dmem_ready;
   logic        pc_write_en, if_id_write_en, if_id_flush;
   logic        id_ex_bubble, ex_mem_bubble;
   logic        id_ex_hold, ex_mem_hold, mem_wb_hold;
   logic [15:0] stall_cnt, flush_cnt;

   logic [7:0]  ctrl;
   logic [7:0]  exp_q[$];
   int          checks;
   int          failures;
   logic [15:0] exp_stall, exp_flush;

   // {pc_we, ifid_we, flush, idex_bubble, exmem_bubble, idex_hold, exmem_hold, memwb_hold}
   localparam logic [7:0] ORun    = 8'b1100_0000;
   localparam logic [7:0] OFreeze = 8'b0000_0111;
   localparam logic [7:0] ORedir  = 8'b1111_1000;
   localparam logic [7:0] OLu     = 8'b0001_0000;
   localparam logic [7:0] ORst    = 8'b0011_1000;

   hazard_ctrl u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .ex_memRead     (ex_memRead),
      .ex_rd          (ex_rd),
      .mem_redirect   (mem_redirect),
      .dmem_req       (dmem_req),
      .dmem_ready     (dmem_ready),
      .pc_write_en    (pc_write_en),
      .if_id_write_en (if_id_write_en),
      .if_id_flush    (if_id_flush),
      .id_ex_bubble   (id_ex_bubble),
      .ex_mem_bubble  (ex_mem_bubble),
      .id_ex_hold     (id_ex_hold),
      .ex_mem_hold    (ex_mem_hold),
      .mem_wb_hold    (mem_wb_hold),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   assign ctrl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_bubble,
                  id_ex_hold, ex_mem_hold, mem_wb_hold};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Push the expected control vector, compare mid-cycle, then advance and check counters.
   task automatic step(input string tag, input logic [7:0] expv);
      logic [7:0] e;
      exp_q.push_back(expv);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      assert (ctrl === e) else begin
         failures++;
         $error("FAIL %s: ctrl observed=%b expected=%b", tag, ctrl, e);
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         exp_stall = '0;
         exp_flush = '0;
      end else begin
         if (((e == OFreeze) || (e == OLu)) && (exp_stall != 16'hFFFF)) exp_stall++;
         if ((e == ORedir) && (exp_flush != 16'hFFFF)) exp_flush++;
      end
      check16({tag, "/stall_cnt"}, stall_cnt, exp_stall);
      check16({tag, "/flush_cnt"}, flush_cnt, exp_flush);
   endtask

   task automatic idle_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memRead = 1'b0;
      mem_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd);
      ex_memRead = 1'b1; ex_rd = rd; id_rs1 = rd; id_uses_rs1 = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0;
      exp_stall = '0; exp_flush = '0;
      idle_inputs();
      rst_n = 1'b0;
      step("reset", ORst);
      rst_n = 1'b1;
      step("idle", ORun);

      set_lu(5'd5);
      step("lu_rs1", OLu);
      idle_inputs();
      step("lu_clear", ORun);

      ex_memRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
      step("lu_rs2", OLu);
      id_uses_rs2 = 1'b0;
      step("rs2_unused", ORun);
      idle_inputs();
      ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      step("x0_load", ORun);
      idle_inputs();
      set_lu(5'd9); ex_memRead = 1'b0;
      step("no_load", ORun);
      idle_inputs();

      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("mem_wait", OFreeze);
      dmem_ready = 1'b1;
      step("mem_release", ORun);
      idle_inputs();

      dmem_req = 1'b1; dmem_ready = 1'b0;
      step("wait_r1", OFreeze);
      mem_redirect = 1'b1;
      step("wait_r2", OFreeze);
      mem_redirect = 1'b0;
      step("wait_r3", OFreeze);
      dmem_ready = 1'b1;
      step("pending_apply", ORedir);
      idle_inputs();
      set_lu(5'd3); mem_redirect = 1'b1;
      step("redirect_slot", ORun);
      mem_redirect = 1'b0;
      step("lu_after_redir", OLu);
      idle_inputs();

      mem_redirect = 1'b1; set_lu(5'd4);
      step("redir_over_lu", ORedir);
      idle_inputs();
      step("redir_state", ORun);
      mem_redirect = 1'b1; set_lu(5'd4); dmem_req = 1'b1;
      step("freeze_over_all", OFreeze);
      mem_redirect = 1'b0; dmem_ready = 1'b1;
      step("freeze_then_redir", ORedir);
      idle_inputs();
      step("back_to_run", ORun);

      dmem_req = 1'b1;
      step("rst_wait1", OFreeze);
      mem_redirect = 1'b1;
      step("rst_wait2", OFreeze);
      rst_n = 1'b0; mem_redirect = 1'b0;
      step("rst_mid_wait", ORst);
      rst_n = 1'b1; idle_inputs();
      step("rst_discard", ORun);

      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 65537; i++) @(posedge clk);
      #1;
      exp_stall = 16'hFFFF;
      check16("saturate", stall_cnt, exp_stall);
      dmem_ready = 1'b1;
      step("sat_release", ORun);
      idle_inputs();
      rst_n = 1'b0;
      step("final_reset", ORst);
      rst_n = 1'b1;
      step("final_idle", ORun);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
